// File: rtl/blink_led.sv
// blink_led: free-running LED blinker producing a 50 % duty square wave of period 2*CNT_NUM clocks
//
// Ports:
//    clk_in    in   1  system clock, all state changes on its rising edge
//    rst_n_in  in   1  synchronous active-low reset
//    led_out   out  1  active-high LED drive, decoded only from registers
//
// Parameters:
//    CNT_NUM     clock cycles per LED half-period (>= 1)
//    PWM_PERIOD  PWM frame length in cycles (>= 1), used only with BLINK_LED_PWM_EN
//    PWM_DUTY    PWM on-cycles per frame (0..PWM_PERIOD), used only with BLINK_LED_PWM_EN
//
// Configuration macro:
//    BLINK_LED_PWM_EN  when defined, a free-running PWM counter dims the LED during its on phase
module blink_led #(
   parameter int CNT_NUM    = 12_500_000,
   parameter int PWM_PERIOD = 16,
   parameter int PWM_DUTY   = 8
) (
   input  logic clk_in,
   input  logic rst_n_in,
   output logic led_out
);
   localparam int CNT_W = (CNT_NUM > 1) ? $clog2(CNT_NUM) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_NUM - 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_phase;
   logic             w_tc;
   if (CNT_NUM < 1) begin : g_cnt_chk
      $error("blink_led: CNT_NUM must be >= 1");
   end
   // With CNT_NUM = 1 the terminal count is 0, so phase flips on every released edge.
   assign w_tc = (r_cnt == CNT_MAX);
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else begin
         r_cnt   <= w_tc ? '0 : r_cnt + 1'b1;
         r_phase <= r_phase ^ w_tc;
      end
   end
`ifdef BLINK_LED_PWM_EN
   localparam int PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam logic [PWM_W-1:0] PWM_MAX = PWM_W'(PWM_PERIOD - 1);
   logic [PWM_W-1:0] r_pwm_cnt;
   logic             w_pwm_on;
   if (PWM_PERIOD < 1) begin : g_pwm_period_chk
      $error("blink_led: PWM_PERIOD must be >= 1");
   end
   if (PWM_DUTY < 0 || PWM_DUTY > PWM_PERIOD) begin : g_pwm_duty_chk
      $error("blink_led: PWM_DUTY must be within 0..PWM_PERIOD");
   end
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) r_pwm_cnt <= '0;
      else           r_pwm_cnt <= (r_pwm_cnt == PWM_MAX) ? '0 : r_pwm_cnt + 1'b1;
   end
   // Compared at 32 bits so PWM_DUTY = PWM_PERIOD keeps the LED on for the whole frame.
   assign w_pwm_on = (32'(r_pwm_cnt) < 32'(PWM_DUTY));
   assign led_out  = r_phase & w_pwm_on;
`else
   // PWM parameters have no effect in this build.
   logic [31:0] w_pwm_unused;
   assign w_pwm_unused = 32'(PWM_PERIOD + PWM_DUTY);
   assign led_out      = r_phase;
`endif
endmodule

// File: tb/tb_blink_led.sv
// tb_blink_led: randomized-reset check of four blink_led instances against an edge-count model
`timescale 1ns/1ps
module tb_blink_led;
   localparam int N = 4;
   int cnt_tab [N]  = '{10, 1, 5, 32};
   int per_tab [N]  = '{16, 16, 16, 4};
   int duty_tab [N] = '{8, 8, 8, 1};
   logic clk = 1'b0;
   logic rst_n [N];
   logic led [N];
   int   k [N];
   int   checks = 0;
   int   errors = 0;

   always #20 clk = ~clk;

   blink_led #(.CNT_NUM(10)) u_dut0 (.clk_in(clk), .rst_n_in(rst_n[0]), .led_out(led[0]));
   blink_led #(.CNT_NUM(1))  u_dut1 (.clk_in(clk), .rst_n_in(rst_n[1]), .led_out(led[1]));
   blink_led #(.CNT_NUM(5))  u_dut2 (.clk_in(clk), .rst_n_in(rst_n[2]), .led_out(led[2]));
   blink_led #(.CNT_NUM(32), .PWM_PERIOD(4), .PWM_DUTY(1))
      u_dut3 (.clk_in(clk), .rst_n_in(rst_n[3]), .led_out(led[3]));

   // Expected LED after k released edges since the last reset edge.
   function automatic logic exp_led(input int kk, input int cn, input int pp, input int pd);
      logic ph;
      ph = ((kk / cn) % 2) == 1;
`ifdef BLINK_LED_PWM_EN
      return ph && ((kk % pp) < pd);
`else
      return ph;
`endif
   endfunction

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rst_n[i] = 1'b0;
         k[i]     = 0;
      end
      for (int r = 0; r < 3; r++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) check($sformatf("reset dut%0d edge%0d", i, r), led[i], 1'b0);
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) rst_n[i] = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
         if (cyc == 14) rst_n[0] = 1'b0;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            k[i] = rst_n[i] ? k[i] + 1 : 0;
            check($sformatf("dut%0d cyc%0d k%0d", i, cyc, k[i]), led[i],
                  exp_led(k[i], cnt_tab[i], per_tab[i], duty_tab[i]));
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
